// File: rtl/mips_multicycle_core.sv
// mips_multicycle_core: multicycle MIPS subset core with unified memory port and memory-mapped IO.
// Bus outputs are decoded from the registered state; everything else is a register.
module mips_multicycle_core #(
    parameter logic [31:0] TEXT_BASE   = 32'h0040_0000,
    parameter logic [31:0] IO_IN_ADDR  = 32'hFFFF_0000,
    parameter logic [31:0] IO_OUT_ADDR = 32'hFFFF_0004,
    parameter int          PORT_IN_W   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [PORT_IN_W-1:0] PortIn,
    output logic [31:0]          PortOut,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [31:0]          mem_addr,
    output logic [31:0]          mem_wdata,
    input  logic                 mem_ready,
    input  logic [31:0]          mem_rdata,
    output logic [31:0]          ALUResultOut,
    output logic                 instr_retired,
    output logic                 illegal
);
    localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                           OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_ANDI = 6'h0C, OP_ORI = 6'h0D,
                           OP_LUI = 6'h0F, OP_LW = 6'h23, OP_SW = 6'h2B;
    localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_JR = 6'h08, F_ADD = 6'h20,
                           F_SUB = 6'h22, F_AND = 6'h24, F_OR = 6'h25, F_SLT = 6'h2A;

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

    state_t      state;
    logic [31:0] pc, ir, a, b, simm, mdr;
    logic [31:0] rf [32];

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, shamt, wb_dst;
    logic [31:0] zimm, alu_res, wb_val;
    logic        is_r, is_jr, is_lw, is_sw, is_br, r_ok, valid, is_io, taken;

    assign op     = ir[31:26];
    assign rs     = ir[25:21];
    assign rt     = ir[20:16];
    assign rd     = ir[15:11];
    assign shamt  = ir[10:6];
    assign funct  = ir[5:0];
    assign zimm   = {16'h0, ir[15:0]};
    assign is_r   = op == OP_R;
    assign is_jr  = is_r && funct == F_JR;
    assign is_lw  = op == OP_LW;
    assign is_sw  = op == OP_SW;
    assign is_br  = op == OP_BEQ || op == OP_BNE;
    assign taken  = op == OP_BEQ ? a == b : a != b;
    assign r_ok   = is_r && (funct inside {F_SLL, F_SRL, F_JR, F_ADD, F_SUB, F_AND, F_OR, F_SLT});
    assign valid  = r_ok || (op inside {OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI,
                                        OP_ORI, OP_LUI, OP_LW, OP_SW});
    assign is_io  = (is_lw && ALUResultOut == IO_IN_ADDR) || (is_sw && ALUResultOut == IO_OUT_ADDR);

    assign alu_res = is_r ? (funct == F_ADD ? a + b :
                             funct == F_SUB ? a - b :
                             funct == F_AND ? a & b :
                             funct == F_OR  ? a | b :
                             funct == F_SLT ? {31'b0, $signed(a) < $signed(b)} :
                             funct == F_SLL ? b << shamt : b >> shamt) :
                     op == OP_ANDI ? a & zimm :
                     op == OP_ORI  ? a | zimm :
                     op == OP_LUI  ? {ir[15:0], 16'h0} : a + simm;

    // jal parks its link value in ALUOut so WB has a single data path besides MDR
    assign wb_dst = is_r ? rd : op == OP_JAL ? 5'd31 : rt;
    assign wb_val = is_lw ? mdr : ALUResultOut;

    assign mem_req       = !reset && (state == FETCH || (state == MEM && !is_io));
    assign mem_we        = mem_req && state == MEM && is_sw;
    assign mem_addr      = state == MEM ? ALUResultOut : pc;
    assign mem_wdata     = b;
    assign instr_retired = state == WB ||
                           (state == EXEC && valid && (is_br || is_jr || op == OP_J)) ||
                           (state == MEM && is_sw && (is_io || mem_ready));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= FETCH;
            pc           <= TEXT_BASE;
            ir           <= '0;
            a            <= '0;
            b            <= '0;
            simm         <= '0;
            mdr          <= '0;
            ALUResultOut <= '0;
            PortOut      <= '0;
            illegal      <= 1'b0;
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else begin
            case (state)
                FETCH: if (mem_ready) begin
                    ir    <= mem_rdata;
                    pc    <= pc + 32'd4;
                    state <= DECODE;
                end
                DECODE: begin
                    a     <= rf[rs];
                    b     <= rf[rt];
                    simm  <= {{16{ir[15]}}, ir[15:0]};
                    state <= EXEC;
                end
                EXEC: if (!valid) begin
                    illegal <= 1'b1;
                    state   <= HALT;
                end else if (op == OP_J || op == OP_JAL) begin
                    pc    <= {pc[31:28], ir[25:0], 2'b00};
                    if (op == OP_JAL) ALUResultOut <= pc;
                    state <= op == OP_JAL ? WB : FETCH;
                end else if (is_jr) begin
                    pc    <= a;
                    state <= FETCH;
                end else if (is_br) begin
                    if (taken) pc <= pc + (simm << 2);
                    state <= FETCH;
                end else begin
                    ALUResultOut <= alu_res;
                    state        <= is_lw || is_sw ? MEM : WB;
                end
                MEM: if (is_io) begin
                    if (is_sw) PortOut <= b;
                    else mdr <= 32'(PortIn);
                    state <= is_sw ? FETCH : WB;
                end else if (mem_ready) begin
                    if (is_lw) mdr <= mem_rdata;
                    state <= is_sw ? FETCH : WB;
                end
                WB: begin
                    if (wb_dst != 5'd0) rf[wb_dst] <= wb_val;
                    state <= FETCH;
                end
                default: state <= HALT;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_multicycle_core.sv
// tb_mips_multicycle_core: directed programs with a store scoreboard and cycle-exact checks.
module tb_mips_multicycle_core;
    logic        clk = 0, reset = 0, tie = 1, io_req = 0;
    logic [7:0]  PortIn = 0;
    logic [31:0] PortOut, mem_addr, mem_wdata, mem_rdata, ALUResultOut;
    logic        mem_req, mem_we, mem_ready, instr_retired, illegal;
    logic [31:0] mem [1024];
    logic [63:0] exp_q [$];
    logic [63:0] wr_e;
    int          checks = 0, errors = 0, cyc = 0, dly = 0, wait_cnt = 0;

    mips_multicycle_core dut (
        .clk(clk), .reset(reset), .PortIn(PortIn), .PortOut(PortOut),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .ALUResultOut(ALUResultOut),
        .instr_retired(instr_retired), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // data accesses (address bit 28 set) wait dly cycles; fetches complete at once
    assign mem_rdata = mem[mem_addr[11:2]];
    assign mem_ready = tie || (mem_req && wait_cnt >= (mem_addr[28] ? dly : 0));
    always @(posedge clk) wait_cnt <= (reset || !mem_req || mem_ready) ? 0 : wait_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) if (!reset) begin
        if (mem_req && mem_addr[31:16] == 16'hFFFF) io_req <= 1;
        if (mem_req && mem_we && mem_ready) begin
            mem[mem_addr[11:2]] <= mem_wdata;
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL wr_unexpected observed=%h:%h expected=none", mem_addr, mem_wdata);
            end
            if (exp_q.size() != 0) begin
                wr_e = exp_q.pop_front();
                chk("wr_addr", mem_addr, wr_e[63:32]);
                chk("wr_data", mem_wdata, wr_e[31:0]);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    function automatic logic [31:0] r_i(int rs, int rt, int rd, int sh, int fn);
        return {6'h0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
    endfunction
    function automatic logic [31:0] i_i(int op, int rs, int rt, int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction
    function automatic logic [31:0] j_i(int op, logic [31:0] target);
        return {6'(op), target[27:2]};
    endfunction

    task automatic start(input logic t, input int d);
        reset = 1;
        tie = t;
        dly = d;
        io_req = 0;
        exp_q.delete();
        foreach (mem[i]) mem[i] = 0;
    endtask
    task automatic release_rst();
        @(posedge clk);
        #1 reset = 0;
        cyc = 0;
    endtask
    task automatic step_to(input int n);
        while (cyc < n) begin
            @(negedge clk);
            cyc++;
        end
    endtask
    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            cyc++;
            n++;
        end
        chk("drain", 32'(exp_q.size()), 0);
        repeat (20) @(negedge clk);
    endtask

    initial begin
        // ALU, immediates, signed slt, wrap-around, $0 immutability
        start(1, 0);
        #1;
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_portout", PortOut, 0);
        chk("rst_alu", ALUResultOut, 0);
        chk("rst_illegal", 32'(illegal), 0);
        chk("rst_retired", 32'(instr_retired), 0);
        mem[0]  = i_i(8, 0, 8, 5);
        mem[1]  = r_i(8, 8, 9, 0, 'h20);
        mem[2]  = i_i(15, 0, 10, 'h1001);
        mem[3]  = i_i('h2B, 10, 9, 'h100);
        mem[4]  = r_i(8, 9, 11, 0, 'h22);
        mem[5]  = i_i('h2B, 10, 11, 'h104);
        mem[6]  = r_i(11, 8, 12, 0, 'h2A);
        mem[7]  = i_i('h2B, 10, 12, 'h108);
        mem[8]  = r_i(8, 11, 12, 0, 'h2A);
        mem[9]  = i_i('h2B, 10, 12, 'h10C);
        mem[10] = i_i('h0D, 0, 13, 'h8001);
        mem[11] = i_i(8, 0, 14, -1);
        mem[12] = i_i('h0C, 14, 15, 'hF0F0);
        mem[13] = i_i('h2B, 10, 15, 'h110);
        mem[14] = r_i(0, 13, 16, 4, 'h00);
        mem[15] = r_i(0, 14, 17, 28, 'h02);
        mem[16] = r_i(16, 17, 19, 0, 'h25);
        mem[17] = i_i('h2B, 10, 19, 'h114);
        mem[18] = r_i(14, 13, 18, 0, 'h24);
        mem[19] = i_i('h2B, 10, 18, 'h118);
        mem[20] = i_i(15, 0, 20, 'h7FFF);
        mem[21] = i_i('h0D, 20, 20, 'hFFFF);
        mem[22] = i_i(8, 20, 21, 1);
        mem[23] = i_i('h2B, 10, 21, 'h11C);
        mem[24] = i_i(8, 0, 0, 7);
        mem[25] = i_i('h2B, 10, 0, 'h120);
        mem[26] = i_i(4, 0, 0, -1);
        exp_q.push_back({32'h1001_0100, 32'd10});
        exp_q.push_back({32'h1001_0104, 32'hFFFF_FFFB});
        exp_q.push_back({32'h1001_0108, 32'd1});
        exp_q.push_back({32'h1001_010C, 32'd0});
        exp_q.push_back({32'h1001_0110, 32'h0000_F0F0});
        exp_q.push_back({32'h1001_0114, 32'h0008_001F});
        exp_q.push_back({32'h1001_0118, 32'h0000_8001});
        exp_q.push_back({32'h1001_011C, 32'h8000_0000});
        exp_q.push_back({32'h1001_0120, 32'd0});
        release_rst();
        step_to(1);
        chk("first_req", 32'(mem_req), 1);
        chk("first_addr", mem_addr, 32'h0040_0000);
        for (int c = 1; c <= 8; c++) begin
            step_to(c);
            chk($sformatf("retire_c%0d", c), 32'(instr_retired), 32'(c == 4 || c == 8));
            if (c == 4) chk("alu_addi", ALUResultOut, 5);
        end
        chk("alu_add", ALUResultOut, 10);
        drain(400);

        // IO load/store bypass
        start(1, 0);
        PortIn = 8'hA5;
        mem[0] = i_i(15, 0, 1, 'hFFFF);
        mem[1] = i_i('h23, 1, 8, 0);
        mem[2] = i_i('h2B, 1, 8, 4);
        mem[3] = i_i(15, 0, 10, 'h1001);
        mem[4] = i_i('h2B, 10, 8, 'h100);
        mem[5] = i_i(4, 0, 0, -1);
        exp_q.push_back({32'h1001_0100, 32'h0000_00A5});
        release_rst();
        step_to(8);
        chk("io_lw_noreq", 32'(mem_req), 0);
        step_to(9);
        chk("io_lw_retire", 32'(instr_retired), 1);
        step_to(12);
        chk("io_sw_exec", 32'(instr_retired), 0);
        step_to(13);
        chk("io_sw_retire", 32'(instr_retired), 1);
        chk("io_sw_noreq", 32'(mem_req), 0);
        chk("io_sw_alu", ALUResultOut, 32'hFFFF_0004);
        step_to(14);
        chk("portout", PortOut, 32'h0000_00A5);
        drain(200);
        chk("io_req_never", 32'(io_req), 0);

        // memory load with three wait cycles
        start(0, 3);
        mem[0]  = i_i(15, 0, 10, 'h1001);
        mem[1]  = i_i('h23, 10, 9, 'h100);
        mem[2]  = i_i('h2B, 10, 9, 'h104);
        mem[3]  = i_i(4, 0, 0, -1);
        mem[64] = 32'hCAFE_F00D;
        exp_q.push_back({32'h1001_0104, 32'hCAFE_F00D});
        release_rst();
        for (int c = 8; c <= 12; c++) begin
            step_to(c);
            if (c < 12) begin
                chk($sformatf("lw_req_c%0d", c), {30'b0, mem_req, mem_we}, 32'h2);
                chk($sformatf("lw_addr_c%0d", c), mem_addr, 32'h1001_0100);
            end
            chk($sformatf("lw_retire_c%0d", c), 32'(instr_retired), 32'(c == 12));
        end
        drain(200);

        // jal / jr / branches / j
        start(1, 0);
        mem[0]  = i_i(15, 0, 10, 'h1001);
        mem[1]  = i_i(8, 0, 8, 3);
        mem[2]  = j_i(3, 32'h0040_0020);
        mem[3]  = i_i('h2B, 10, 31, 'h100);
        mem[4]  = i_i(5, 8, 8, 2);
        mem[5]  = i_i(8, 0, 9, 1);
        mem[6]  = i_i('h2B, 10, 9, 'h104);
        mem[7]  = i_i(4, 0, 0, -1);
        mem[8]  = i_i(8, 8, 8, 4);
        mem[9]  = i_i(4, 8, 8, 1);
        mem[10] = i_i('h2B, 10, 8, 'h10C);
        mem[11] = i_i('h2B, 10, 8, 'h108);
        mem[12] = j_i(2, 32'h0040_0034);
        mem[13] = r_i(31, 0, 0, 0, 'h08);
        exp_q.push_back({32'h1001_0108, 32'd7});
        exp_q.push_back({32'h1001_0100, 32'h0040_000C});
        exp_q.push_back({32'h1001_0104, 32'd1});
        release_rst();
        step_to(12);
        chk("jal_retire", 32'(instr_retired), 1);
        step_to(13);
        chk("jal_target", mem_addr, 32'h0040_0020);
        step_to(19);
        chk("beq_retire", 32'(instr_retired), 1);
        step_to(20);
        chk("beq_target", mem_addr, 32'h0040_002C);
        drain(300);

        // illegal opcode halts; reset recovers
        start(1, 0);
        mem[0] = i_i(8, 0, 8, 1);
        mem[1] = 32'hFC00_0000;
        release_rst();
        step_to(7);
        chk("pre_halt_illegal", 32'(illegal), 0);
        for (int c = 8; c <= 20; c++) begin
            step_to(c);
            chk($sformatf("halt_c%0d", c), {29'b0, illegal, mem_req, instr_retired}, 32'h4);
        end
        #2 reset = 1;
        #1;
        chk("halt_rst_illegal", 32'(illegal), 0);
        chk("halt_rst_req", 32'(mem_req), 0);
        release_rst();
        step_to(1);
        chk("refetch_req", 32'(mem_req), 1);
        chk("refetch_addr", mem_addr, 32'h0040_0000);

        // reset during a stalled store aborts it
        start(0, 3);
        mem[0] = i_i(15, 0, 10, 'h1001);
        mem[1] = i_i(8, 0, 9, 'h55);
        mem[2] = i_i('h2B, 10, 9, 'h100);
        release_rst();
        step_to(13);
        chk("abort_sw_pending", {30'b0, mem_req, mem_we}, 32'h3);
        #2 reset = 1;
        #1;
        chk("abort_req", 32'(mem_req), 0);
        chk("abort_portout", PortOut, 0);
        repeat (10) @(negedge clk);
        chk("abort_no_write", mem[64], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mips_multicycle_core.md
MIPS_MULTICYCLE_CORE -- requirements
Module: mips_multicycle_core

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- TEXT_BASE, 32'h0040_0000, PC reset value.
- IO_IN_ADDR, 32'hFFFF_0000, load address that returns PortIn.
- IO_OUT_ADDR, 32'hFFFF_0004, store address that writes PortOut.
- PORT_IN_W, 8, PortIn width (1..32).
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, single clock, rising edge.
- reset, in, 1, asynchronous, active-high.
- PortIn, in, PORT_IN_W, input port.
- PortOut, out, 32, output port register.
- mem_req, out, 1, memory request.
- mem_we, out, 1, write when 1, read when 0.
- mem_addr, out, 32, byte address.
- mem_wdata, out, 32, store data.
- mem_ready, in, 1, transaction completes on this edge.
- mem_rdata, in, 32, read data, valid with mem_ready.
- ALUResultOut, out, 32, last ALU result register.
- instr_retired, out, 1, one-cycle pulse per completed instruction.
- illegal, out, 1, sticky illegal-opcode flag.

Function
REQ-003 The core SHALL be one clock domain with unified instruction/data memory and an internal 32x32 register file; $0 SHALL always read 0 and ignore writes.
REQ-004 Supported instructions SHALL be add, sub, and, or, slt, sll, srl, jr (R-type); addi, andi, ori, lui, lw, sw, beq, bne; j, jal.
REQ-005 The FSM SHALL have the states FETCH, DECODE, EXEC, MEM, WB and HALT.
REQ-006 FETCH SHALL drive mem_req=1, mem_we=0, mem_addr=PC; when mem_ready=1, IR SHALL load mem_rdata, PC SHALL become PC+4, and the FSM SHALL go to DECODE; otherwise FETCH SHALL hold with all outputs stable.
REQ-007 DECODE SHALL register A=rs, B=rt and the sign-extended immediate, then go to EXEC.
REQ-008 EXEC SHALL operate per opcode:
- R-type and I-type ALU: SHALL compute into ALUOut, then go to WB.
- lw/sw: SHALL compute address A+simm, then go to MEM.
- beq/bne: if taken, SHALL set PC=PC+(simm<<2); SHALL retire and go to FETCH.
- j: SHALL set PC={PC[31:28],imm26,2'b00}; SHALL retire and go to FETCH.
- jal: SHALL set the same jump target, then go to WB to write PC(+4 value) to $31.
- jr: SHALL set PC=A; SHALL retire and go to FETCH.
- Unknown opcode or funct: SHALL go to HALT.
REQ-009 Immediate handling SHALL be: andi/ori zero-extend; addi/lw/sw/branches sign-extend; lui gives {imm,16'h0}.
REQ-010 slt SHALL be a signed compare; add/addi overflow SHALL wrap with no trap.
REQ-011 In MEM, an address equal to IO_IN_ADDR (lw) or IO_OUT_ADDR (sw) SHALL bypass memory: mem_req SHALL stay 0 and the access SHALL complete in one cycle.
REQ-012 An IO lw SHALL return PortIn zero-extended to 32 bits; an IO sw SHALL load PortOut.
REQ-013 Any other MEM access SHALL drive mem_req=1, mem_we=(sw), mem_addr and mem_wdata=B, held stable until mem_ready=1.
REQ-014 On completion, sw SHALL retire and go to FETCH; lw SHALL latch mem_rdata into MDR and go to WB.
REQ-015 WB SHALL write ALUOut (R-type to rd, I-type to rt), MDR (lw to rt) or the link value (jal to $31), SHALL retire, and SHALL go to FETCH.
REQ-016 instr_retired SHALL be high for exactly one cycle, on the final state of each instruction.
REQ-017 ALUResultOut SHALL update whenever ALUOut is written.
REQ-018 Latency with mem_ready tied to 1 SHALL be: beq/bne/j/jr 3 cycles; R/I-ALU, jal, sw and IO lw/sw 4 (IO lw 5); memory lw 5.
REQ-019 In HALT, illegal SHALL be 1, mem_req SHALL be 0, and the core SHALL remain in HALT until reset.
REQ-020 mem_ready asserted while mem_req=0 SHALL be ignored.
REQ-021 A branch target SHALL wrap modulo 2^32.

Reset
REQ-022 While reset=1, asynchronously: PC SHALL be TEXT_BASE, the state SHALL be FETCH, and all registers, PortOut, ALUResultOut, IR, instr_retired and illegal SHALL be 0.
REQ-023 mem_req SHALL be 0 while reset=1; the first fetch request SHALL occur in the first cycle after release.
REQ-024 Reset asserted mid-transaction SHALL abort the transaction with no register-file or PortOut write.

Verification
REQ-025 Reset release, mem_ready=1 -> mem_req=1 with mem_addr=32'h0040_0000 in the first cycle after release.
REQ-026 addi $8,$0,5; add $9,$8,$8 -> $9=10, ALUResultOut=10, instr_retired pulses at cycles 4 and 8.
REQ-027 lw $t0 from IO_IN_ADDR with PortIn=8'hA5, then sw $t0 to IO_OUT_ADDR -> PortOut=32'h0000_00A5, and mem_req never rises for either access.
REQ-028 Memory lw with mem_ready delayed 3 cycles -> mem_addr/mem_we held stable for 4 cycles, rt=mem_rdata, 8 cycles total.
REQ-029 jal to label, then jr $31 -> $31=return address, PC returns to the jal address + 4; bne with equal operands is not taken.
REQ-030 Opcode 6'h3F -> illegal=1, mem_req=0 forever; reset asserted in HALT -> clears illegal and refetches from TEXT_BASE.
